// File: rtl/modea_reply_decoder_if.sv
// Sample stream in from the RX magnitude stage, decoded Mode A reply out to the logger.
interface modea_reply_decoder_if;
    logic        sample_valid;
    logic [11:0] sample_mag;
    logic        reply_valid;
    logic [11:0] code;
    logic        x_bit;
    logic        spi;
    logic        frame_err;
    logic        busy;

    modport master (
        output sample_valid, sample_mag,
        input  reply_valid, code, x_bit, spi, frame_err, busy
    );

    modport slave (
        input  sample_valid, sample_mag,
        output reply_valid, code, x_bit, spi, frame_err, busy
    );
endinterface

// File: rtl/modea_reply_decoder.sv
// Mode A reply decoder: finds the F1 rising edge in the RX magnitude stream and samples 18 pulse slots.
// Strobes 1 cycle after the slot-17 sample; no backpressure, sample_valid gaps only stretch timing.
module modea_reply_decoder #(
    parameter int unsigned SLOT      = 29,
    parameter int unsigned PULSE_MID = 4,
    parameter logic [11:0] THRESH    = 12'd1024
) (
    input  logic                 chipclock,
    input  logic                 rst,
    modea_reply_decoder_if.slave rx
);
    localparam int unsigned CW = $clog2(18 * SLOT);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t        state;
    logic          prev_hi;
    logic          hi;
    logic          rise;
    logic          cap;
    logic [CW-1:0] offset;
    logic [CW-1:0] off_nxt;
    logic [CW-1:0] cap_off;
    logic [4:0]    slot_idx;
    logic [14:0]   bits;
    logic          reply_valid_q;
    logic          frame_err_q;
    logic          busy_q;
    logic          x_bit_q;
    logic          spi_q;
    logic [11:0]   code_q;

    assign hi      = (rx.sample_mag >= THRESH);
    assign rise    = rx.sample_valid && hi && !prev_hi;
    assign off_nxt = offset + CW'(1);
    assign cap     = (off_nxt == cap_off);

    always_ff @(posedge chipclock or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            prev_hi       <= 1'b1;
            offset        <= '0;
            cap_off       <= '0;
            slot_idx      <= '0;
            bits          <= '0;
            reply_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            x_bit_q       <= 1'b0;
            spi_q         <= 1'b0;
            code_q        <= '0;
        end else begin
            reply_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (rx.sample_valid) prev_hi <= hi;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= COLLECT;
                        busy_q <= 1'b1;
                        offset <= '0;
                        // A zero centre offset puts the F1 capture on the edge sample itself.
                        if (PULSE_MID == 0) begin
                            bits     <= 15'd1;
                            slot_idx <= 5'd1;
                            cap_off  <= CW'(SLOT);
                        end else begin
                            bits     <= '0;
                            slot_idx <= '0;
                            cap_off  <= CW'(PULSE_MID);
                        end
                    end
                end

                COLLECT: begin
                    if (rx.sample_valid) begin
                        offset <= off_nxt;
                        if (cap) begin
                            slot_idx <= slot_idx + 5'd1;
                            cap_off  <= cap_off + CW'(SLOT);
                            if (slot_idx <= 5'd14) bits[slot_idx[3:0]] <= hi;
                            if (slot_idx == 5'd0 && !hi) begin
                                state       <= IDLE;
                                busy_q      <= 1'b0;
                                frame_err_q <= 1'b1;
                            end else if (slot_idx == 5'd17) begin
                                state <= CHECK;
                                if (bits[0] && bits[14]) begin
                                    reply_valid_q <= 1'b1;
                                    code_q        <= {bits[6],  bits[4],  bits[2],
                                                      bits[12], bits[10], bits[8],
                                                      bits[5],  bits[3],  bits[1],
                                                      bits[13], bits[11], bits[9]};
                                    x_bit_q       <= bits[7];
                                    spi_q         <= hi;
                                end else begin
                                    frame_err_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                CHECK: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.reply_valid = reply_valid_q;
    assign rx.frame_err   = frame_err_q;
    assign rx.busy        = busy_q;
    assign rx.code        = code_q;
    assign rx.x_bit       = x_bit_q;
    assign rx.spi         = spi_q;
endmodule

// File: tb/tb_modea_reply_decoder.sv
// Directed bench for modea_reply_decoder: frames are synthesised from octal codes, expected strobes queued.
module tb_modea_reply_decoder;
    localparam int          SLOT   = 29;
    localparam logic [11:0] THRESH = 12'd1024;
    localparam logic [11:0] HI_MAG = THRESH + 12'd100;
    localparam logic [11:0] LO_MAG = 12'd0;

    typedef struct {
        bit          is_err;
        logic [11:0] code;
        bit          x;
        bit          spi;
        int          cyc;
    } exp_t;

    logic chipclock = 1'b0;
    logic rst       = 1'b0;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_fail    = 0;
    int   busy_run  = 0;
    int   last_busy = 0;
    int   err_seen  = 0;
    exp_t sb[$];
    exp_t got;

    modea_reply_decoder_if ifc ();

    modea_reply_decoder dut (
        .chipclock (chipclock),
        .rst       (rst),
        .rx        (ifc.slave)
    );

    always #5 chipclock = ~chipclock;
    always @(posedge chipclock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every reply/frame_err must match the oldest queued expectation.
    always @(negedge chipclock) begin
        if (!rst) begin
            busy_run = 0;
        end else begin
            if (ifc.busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
            if (ifc.reply_valid || ifc.frame_err) begin
                if (ifc.frame_err) err_seen++;
                check("strobe_exclusive", {31'd0, ifc.reply_valid & ifc.frame_err}, 32'd0);
                check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    check("strobe_kind", {31'd0, ifc.frame_err}, {31'd0, got.is_err});
                    check("strobe_cycle", cyc, got.cyc);
                    if (!got.is_err) begin
                        check("code", {20'd0, ifc.code}, {20'd0, got.code});
                        check("x_bit", {31'd0, ifc.x_bit}, {31'd0, got.x});
                        check("spi", {31'd0, ifc.spi}, {31'd0, got.spi});
                    end
                end
            end
        end
    end

    task automatic drive(input logic [11:0] m, input logic v);
        @(negedge chipclock);
        ifc.sample_valid = v;
        ifc.sample_mag   = m;
    endtask

    task automatic silence(input int n);
        for (int i = 0; i < n; i++) drive(LO_MAG, 1'b1);
    endtask

    function automatic logic [17:0] build_slots(input logic [11:0] c, input bit x, input bit s, input bit f2);
        logic [17:0] v;
        v = '0;
        v[0]  = 1'b1;  v[1]  = c[3];  v[2]  = c[9];  v[3]  = c[4];
        v[4]  = c[10]; v[5]  = c[5];  v[6]  = c[11]; v[7]  = x;
        v[8]  = c[6];  v[9]  = c[0];  v[10] = c[7];  v[11] = c[1];
        v[12] = c[8];  v[13] = c[2];  v[14] = f2;    v[17] = s;
        return v;
    endfunction

    // Pulses are 9 samples wide from each slot start; alt inserts an invalid cycle of inverted garbage.
    task automatic send_frame(input logic [11:0] c, input bit x, input bit s, input bit f2,
                              input bit alt, input int abort_at,
                              input logic [11:0] hi_m, input logic [11:0] lo_m);
        logic [17:0] slots;
        exp_t        e;
        slots = build_slots(c, x, s, f2);
        for (int j = 0; j < 18 * SLOT; j++) begin
            logic [4:0]  k;
            logic [11:0] m;
            k = 5'(j / SLOT);
            m = (slots[k] && (j % SLOT) < 9) ? hi_m : lo_m;
            drive(m, 1'b1);
            if (j == 0 && abort_at < 0) begin
                e.is_err = !f2;
                e.code   = c;
                e.x      = x;
                e.spi    = s;
                e.cyc    = cyc + (alt ? 995 : 498);
                sb.push_back(e);
            end
            if (j == abort_at) begin
                rst = 1'b0;
                for (int r = 0; r < 2; r++) begin
                    @(negedge chipclock);
                    check("rst_outputs", {18'd0, ifc.reply_valid, ifc.frame_err, ifc.busy,
                                          ifc.x_bit, ifc.spi, ifc.code}, 32'd0);
                end
                rst = 1'b1;
                break;
            end
            if (alt) drive(~m, 1'b0);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge chipclock);
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int errs_before;
        ifc.sample_valid = 1'b0;
        ifc.sample_mag   = 12'd0;
        repeat (3) @(negedge chipclock);
        check("reset_state", {18'd0, ifc.reply_valid, ifc.frame_err, ifc.busy,
                              ifc.x_bit, ifc.spi, ifc.code}, 32'd0);
        rst = 1'b1;

        // Constant high straight out of reset must not look like an edge.
        repeat (10) drive(HI_MAG, 1'b1);
        check("no_trigger_const_high", {31'd0, ifc.busy}, 32'd0);
        silence(5);

        send_frame(12'hFC0, 1'b0, 1'b0, 1'b1, 1'b0, -1, HI_MAG, LO_MAG);
        silence(10);
        wait_drain("drain_7700");
        check("busy_len_7700", last_busy, 32'd498);
        check("hold_code_7700", {20'd0, ifc.code}, 32'hFC0);

        errs_before = err_seen;
        send_frame(12'h280, 1'b1, 1'b1, 1'b1, 1'b0, -1, HI_MAG, LO_MAG);
        silence(10);
        wait_drain("drain_1200");
        check("no_err_1200", err_seen, errs_before);

        send_frame(12'hFC0, 1'b0, 1'b0, 1'b0, 1'b0, -1, HI_MAG, LO_MAG);
        silence(10);
        wait_drain("drain_nof2");
        check("held_code_after_err", {20'd0, ifc.code}, 32'h280);
        check("held_x_after_err", {31'd0, ifc.x_bit}, 32'd1);
        check("held_spi_after_err", {31'd0, ifc.spi}, 32'd1);

        // Two-sample glitch: F1 centre (offset 4) is low.
        begin
            exp_t e;
            drive(HI_MAG, 1'b1);
            e.is_err = 1'b1;
            e.code   = 12'h0;
            e.x      = 1'b0;
            e.spi    = 1'b0;
            e.cyc    = cyc + 5;
            sb.push_back(e);
            drive(HI_MAG, 1'b1);
        end
        silence(20);
        wait_drain("drain_glitch");
        check("idle_after_glitch", {31'd0, ifc.busy}, 32'd0);
        check("code_after_glitch", {20'd0, ifc.code}, 32'h280);

        // Levels sit exactly on the threshold boundary.
        send_frame(12'h249, 1'b0, 1'b1, 1'b1, 1'b0, -1, THRESH, THRESH - 12'd1);
        silence(10);
        wait_drain("drain_1111");

        send_frame(12'hFC0, 1'b1, 1'b0, 1'b1, 1'b1, -1, HI_MAG, LO_MAG);
        silence(10);
        wait_drain("drain_alt");

        send_frame(12'hFC0, 1'b1, 1'b1, 1'b1, 1'b0, 200, HI_MAG, LO_MAG);
        silence(10);
        check("idle_after_rst", {31'd0, ifc.busy}, 32'd0);
        send_frame(12'h041, 1'b0, 1'b0, 1'b1, 1'b0, -1, HI_MAG, LO_MAG);
        silence(10);
        wait_drain("drain_0101");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
